// File: rtl/onehot_to_bin_stream.sv
// onehot_to_bin_stream: streaming one-hot to binary encoder with a
// valid/ready handshake, 2-entry spill register and error counter.
//
// Ports:
//   clk_i          clock
//   rst_i          synchronous reset, active-high
//   in_valid_i     input beat valid
//   in_ready_o     input beat accepted when valid & ready (registered)
//   in_onehot_i    one-hot (or multi-hot) input vector
//   out_valid_o    output beat valid
//   out_ready_i    downstream ready
//   out_bin_o      encoded index of the head beat
//   out_onehot_o   cleaned one-hot of the head beat (selected bit only)
//   out_err_o      head beat was illegal for MODE
//   err_cnt_clr_i  clear the error counter
//   err_cnt_o      saturating count of accepted error beats
module onehot_to_bin_stream #(
    parameter int ONEHOT_WIDTH = 16,
    parameter int BIN_WIDTH    = (ONEHOT_WIDTH == 1) ? 1 : $clog2(ONEHOT_WIDTH),
    parameter int MODE         = 0,
    parameter int CNT_WIDTH    = 8
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    in_valid_i,
    output logic                    in_ready_o,
    input  logic [ONEHOT_WIDTH-1:0] in_onehot_i,
    output logic                    out_valid_o,
    input  logic                    out_ready_i,
    output logic [BIN_WIDTH-1:0]    out_bin_o,
    output logic [ONEHOT_WIDTH-1:0] out_onehot_o,
    output logic                    out_err_o,
    input  logic                    err_cnt_clr_i,
    output logic [CNT_WIDTH-1:0]    err_cnt_o
);

    localparam bit STRICT  = (MODE == 0);
    localparam bit MSB_PRI = (MODE == 2);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    typedef struct packed {
        logic [BIN_WIDTH-1:0]    bin;
        logic [ONEHOT_WIDTH-1:0] onehot;
        logic                    err;
    } beat_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    // ------------------------------------------------------------
    // Encoder
    // ------------------------------------------------------------
    logic                 is_zero;
    logic                 is_multi;
    logic [BIN_WIDTH-1:0] lsb_idx;
    logic [BIN_WIDTH-1:0] msb_idx;
    logic                 lsb_found;
    beat_t                enc;

    assign is_zero = ~|in_onehot_i;

    // v & (v-1) clears the lowest set bit; anything left means multi-hot.
    assign is_multi = |(in_onehot_i & (in_onehot_i - ONEHOT_WIDTH'(1)));

    always_comb begin
        lsb_idx   = '0;
        lsb_found = 1'b0;
        for (int i = 0; i < ONEHOT_WIDTH; i++) begin
            if (!lsb_found && in_onehot_i[i]) begin
                lsb_idx   = BIN_WIDTH'(i);
                lsb_found = 1'b1;
            end
        end
    end

    always_comb begin
        msb_idx = '0;
        for (int i = 0; i < ONEHOT_WIDTH; i++) begin
            if (in_onehot_i[i]) begin
                msb_idx = BIN_WIDTH'(i);
            end
        end
    end

    // A single set bit falls through to the default arm, where the
    // lowest set index is also the only one.
    always_comb begin
        enc = '0;
        unique case (1'b1)
            is_zero: begin
                enc.err = 1'b1;
            end
            is_multi && STRICT: begin
                enc.err = 1'b1;
            end
            is_multi && MSB_PRI: begin
                enc.bin    = msb_idx;
                enc.onehot = ONEHOT_WIDTH'(1) << msb_idx;
            end
            default: begin
                enc.bin    = lsb_idx;
                enc.onehot = ONEHOT_WIDTH'(1) << lsb_idx;
            end
        endcase
    end

    // ------------------------------------------------------------
    // Spill register control
    // ------------------------------------------------------------
    state_t state_q;
    state_t state_d;
    logic   ready_q;
    logic   accept;
    logic   pop;
    logic   load_a;
    logic   load_b;
    logic   move_b;
    beat_t  slot_a_q;
    beat_t  slot_b_q;

    assign accept = in_valid_i & ready_q;
    assign pop    = out_valid_o & out_ready_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= EMPTY;
            ready_q <= 1'b1;
        end else begin
            state_q <= state_d;
            // Ready follows the next state so it is a plain flop output.
            ready_q <= (state_d != FULL);
        end
    end

    always_comb begin
        state_d = state_q;
        load_a  = 1'b0;
        load_b  = 1'b0;
        move_b  = 1'b0;
        unique case (state_q)
            EMPTY: begin
                if (accept) begin
                    state_d = ONE;
                    load_a  = 1'b1;
                end
            end
            ONE: begin
                if (accept && pop) begin
                    load_a = 1'b1;
                end else if (accept) begin
                    state_d = FULL;
                    load_b  = 1'b1;
                end else if (pop) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                if (pop) begin
                    state_d = ONE;
                    move_b  = 1'b1;
                end
            end
            default: begin
                state_d = EMPTY;
            end
        endcase
    end

    // ------------------------------------------------------------
    // Slot storage
    // ------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            slot_a_q <= '0;
        end else if (load_a) begin
            slot_a_q <= enc;
        end else if (move_b) begin
            slot_a_q <= slot_b_q;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            slot_b_q <= '0;
        end else if (load_b) begin
            slot_b_q <= enc;
        end
    end

    // ------------------------------------------------------------
    // Error counter, counted at accept time
    // ------------------------------------------------------------
    logic [CNT_WIDTH-1:0] cnt_q;

    always_ff @(posedge clk_i) begin
        if (rst_i || err_cnt_clr_i) begin
            cnt_q <= '0;
        end else if (accept && enc.err && (cnt_q != CNT_MAX)) begin
            cnt_q <= cnt_q + CNT_WIDTH'(1);
        end
    end

    // ------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------
    assign in_ready_o   = ready_q;
    assign out_valid_o  = (state_q != EMPTY);
    assign out_bin_o    = slot_a_q.bin;
    assign out_onehot_o = slot_a_q.onehot;
    assign out_err_o    = slot_a_q.err;
    assign err_cnt_o    = cnt_q;

endmodule
